// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1 by default, deserialising uart_rxd into bytes.
// The received byte is offered on a one-entry valid/ready holding register.
//
// Configuration macro: UART_RX_PARITY_EN
//   undefined - 8N1 frames, no rx_parity_err port
//   defined   - 8E1 frames: a PARITY state sits between DATA and STOP, and
//               rx_parity_err is added
//
// Ports:
//   osc_clk       clock
//   osc_reset     asynchronous active-high reset
//   uart_rxd      serial line, idle high, asynchronous to osc_clk
//   rx_valid      rx_data holds an unconsumed byte
//   rx_ready      consumer accepts the byte when rx_valid && rx_ready
//   rx_data       received byte
//   rx_frame_err  one-cycle pulse: stop bit sampled low
//   rx_overrun    one-cycle pulse: byte dropped because the holding register was full
//   rx_parity_err one-cycle pulse: even-parity mismatch (UART_RX_PARITY_EN only)
//   rx_busy       high whenever the receiver is not idle
module uart_rx #(
    parameter int unsigned CLK_DIV = 217  // osc_clk cycles per bit, >= 4
) (
    input  logic       osc_clk,
    input  logic       osc_reset,
    input  logic       uart_rxd,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_frame_err,
    output logic       rx_overrun,
`ifdef UART_RX_PARITY_EN
    output logic       rx_parity_err,
`endif
    output logic       rx_busy
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] CntBit  = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } state_e;

    state_e          state;
    logic            rxd_meta;
    logic            rxd_s;
    logic [CntW-1:0] cnt;
    logic [2:0]      idx;
    logic [7:0]      shreg;
    logic            deliver;  // stop bit accepted last cycle; shreg holds the byte
`ifdef UART_RX_PARITY_EN
    logic            par_bad;
`endif

    // State decode of a flop; no IDLE glitches.
    assign rx_busy = (state != StIdle);

    always_ff @(posedge osc_clk or posedge osc_reset) begin
        if (osc_reset) begin
            rxd_meta     <= 1'b1;
            rxd_s        <= 1'b1;
            state        <= StIdle;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            deliver      <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
            par_bad       <= 1'b0;
`endif
        end else begin
            rxd_meta     <= uart_rxd;
            rxd_s        <= rxd_meta;
            deliver      <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif

            // Holding register: a coinciding delivery overrides the consume.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end

            case (state)
                StIdle: begin
                    if (!rxd_s) begin
                        cnt   <= CntHalf;
                        state <= StStart;
                    end
                end
                StStart: begin
                    if (cnt == '0) begin
                        if (!rxd_s) begin
                            cnt   <= CntBit;
                            idx   <= '0;
                            state <= StData;
                        end else begin
                            state <= StIdle;  // glitch shorter than half a bit
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StData: begin
                    if (cnt == '0) begin
                        shreg <= {rxd_s, shreg[7:1]};
                        cnt   <= CntBit;
                        idx   <= idx + 1'b1;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= StParity;
`else
                            state <= StStop;
`endif
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (cnt == '0) begin
                        par_bad <= (rxd_s != ^shreg);
                        cnt     <= CntBit;
                        state   <= StStop;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                StStop: begin
                    // Leaving at mid-stop-bit lets a start bit right after a
                    // one-bit stop be caught on its falling edge.
                    if (cnt == '0) begin
                        if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                rx_parity_err <= 1'b1;
                            end else begin
                                deliver <= 1'b1;
                            end
`else
                            deliver <= 1'b1;
`endif
                            state <= StIdle;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= StBreak;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StBreak: begin
                    // A line held low must not look like a stream of start bits.
                    if (rxd_s) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
